audio_i2s_out: RTL and testbench

//  Downstream sink of the PSG. Mixes PSG and PCM stereo samples with saturation and

---
 rtl/audio_i2s_out.sv | 86 ++++++++
 tb/tb_audio_i2s_out.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/audio_i2s_out.sv
// rtl/audio_i2s_out.sv - PSG/PCM saturating mixer and I2S serializer, audio sample-rate master
module audio_i2s_out #(
  parameter int BCK_HALF  = 4,
  parameter int SLOT_BITS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] psg_left,
  input  logic [15:0] psg_right,
  input  logic [15:0] pcm_left,
  input  logic [15:0] pcm_right,
  input  logic        mute,
  output logic        next_sample,
  output logic        i2s_bck,
  output logic        i2s_lrck,
  output logic        i2s_data
);

  localparam int DW = (2 * BCK_HALF > 1) ? $clog2(2 * BCK_HALF) : 1;
  localparam int BW = $clog2(2 * SLOT_BITS);

  logic [DW-1:0] div_cnt, div_nxt;
  logic [BW-1:0] bit_cnt, bit_nxt;
  logic [15:0]   hold_l, hold_r, hold_l_nxt, hold_r_nxt;
  logic          frame_end;
  logic          lrck_nxt, data_nxt;
  logic [BW-1:0] pos;
  logic [3:0]    idx;
  logic [15:0]   word;

  // Two's-complement add with clamping; overflow shows as differing top two sum bits.
  function automatic logic [15:0] mix(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {a[15], a} + {b[15], b};
    if (s[16:15] == 2'b01)      mix = 16'h7FFF;
    else if (s[16:15] == 2'b10) mix = 16'h8000;
    else                        mix = s[15:0];
  endfunction

  assign frame_end = (div_cnt == DW'(2 * BCK_HALF - 1)) && (bit_cnt == BW'(2 * SLOT_BITS - 1));

  // Outputs are registered from the next counter state so they line up with (d,b).
  always_comb begin
    div_nxt    = div_cnt + DW'(1);
    bit_nxt    = bit_cnt;
    hold_l_nxt = hold_l;
    hold_r_nxt = hold_r;
    if (div_cnt == DW'(2 * BCK_HALF - 1)) begin
      div_nxt = '0;
      bit_nxt = (bit_cnt == BW'(2 * SLOT_BITS - 1)) ? '0 : bit_cnt + BW'(1);
    end
    if (frame_end) begin
      hold_l_nxt = mute ? 16'h0000 : mix(psg_left, pcm_left);
      hold_r_nxt = mute ? 16'h0000 : mix(psg_right, pcm_right);
    end
    lrck_nxt = (bit_nxt >= BW'(SLOT_BITS));
    pos      = lrck_nxt ? bit_nxt - BW'(SLOT_BITS) : bit_nxt;
    word     = lrck_nxt ? hold_r_nxt : hold_l_nxt;
    idx      = 4'(BW'(16) - pos);
    data_nxt = 1'b0;
    if (pos >= BW'(1) && pos <= BW'(16)) data_nxt = word[idx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      hold_l      <= '0;
      hold_r      <= '0;
      next_sample <= 1'b0;
      i2s_bck     <= 1'b0;
      i2s_lrck    <= 1'b0;
      i2s_data    <= 1'b0;
    end else begin
      div_cnt     <= div_nxt;
      bit_cnt     <= bit_nxt;
      hold_l      <= hold_l_nxt;
      hold_r      <= hold_r_nxt;
      next_sample <= frame_end;
      i2s_bck     <= (div_nxt >= DW'(BCK_HALF));
      i2s_lrck    <= lrck_nxt;
      i2s_data    <= data_nxt;
    end
  end

endmodule

// File: tb/tb_audio_i2s_out.sv
// tb/tb_audio_i2s_out.sv - bench for audio_i2s_out at default and minimum parameters
module tb_audio_i2s_out;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] psg_l, psg_r, pcm_l, pcm_r;
  logic        mute;
  logic [1:0]  ns, bck, lr, dat;

  audio_i2s_out #(.BCK_HALF(4), .SLOT_BITS(32)) u0 (
    .clk(clk), .rst_n(rst_n), .psg_left(psg_l), .psg_right(psg_r),
    .pcm_left(pcm_l), .pcm_right(pcm_r), .mute(mute),
    .next_sample(ns[0]), .i2s_bck(bck[0]), .i2s_lrck(lr[0]), .i2s_data(dat[0]));

  audio_i2s_out #(.BCK_HALF(1), .SLOT_BITS(17)) u1 (
    .clk(clk), .rst_n(rst_n), .psg_left(psg_l), .psg_right(psg_r),
    .pcm_left(pcm_l), .pcm_right(pcm_r), .mute(mute),
    .next_sample(ns[1]), .i2s_bck(bck[1]), .i2s_lrck(lr[1]), .i2s_data(dat[1]));

  int          hh[2] = '{4, 1};
  int          ss[2] = '{32, 17};
  int          cyc[2];
  logic [15:0] ml[2], mr[2], sh[2], cap_l[2], cap_r[2];
  bit          first_ns[2];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", name, k, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_mix(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  // Reference: cycles since reset determine everything; inputs taken at the last cycle of a frame.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        cyc[k] = 0;
        ml[k] = 16'h0;
        mr[k] = 16'h0;
        first_ns[k] = 1'b1;
      end else begin
        if (cyc[k] % (4 * hh[k] * ss[k]) == 4 * hh[k] * ss[k] - 1) begin
          ml[k] = mute ? 16'h0 : ref_mix(psg_l, pcm_l);
          mr[k] = mute ? 16'h0 : ref_mix(psg_r, pcm_r);
        end
        cyc[k]++;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int d, b, p, frame;
      logic el, ed;
      logic [15:0] w;
      frame = 4 * hh[k] * ss[k];
      d  = cyc[k] % (2 * hh[k]);
      b  = (cyc[k] / (2 * hh[k])) % (2 * ss[k]);
      el = (b >= ss[k]);
      p  = b % ss[k];
      w  = el ? mr[k] : ml[k];
      ed = (p >= 1 && p <= 16) ? w[16 - p] : 1'b0;
      chk("next_sample", k, int'(ns[k]), int'(cyc[k] > 0 && cyc[k] % frame == 0));
      chk("bck", k, int'(bck[k]), int'(d >= hh[k]));
      chk("lrck", k, int'(lr[k]), int'(el));
      chk("data", k, int'(dat[k]), int'(ed));
      if (first_ns[k] && ns[k]) begin
        chk("first_pulse_cycle", k, cyc[k], (k == 0) ? 512 : 68);
        first_ns[k] = 1'b0;
      end
      if (d == hh[k] && p >= 1 && p <= 16) begin
        sh[k] = {sh[k][14:0], dat[k]};
        if (p == 16) begin
          if (el) cap_r[k] = sh[k];
          else    cap_l[k] = sh[k];
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 5))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic random_run(input int n, input bit use_mute);
    for (int i = 0; i < n; i++) begin
      psg_l = rnd16(); psg_r = rnd16(); pcm_l = rnd16(); pcm_r = rnd16();
      mute  = use_mute && ($urandom_range(0, 3) == 0);
      step(1);
    end
  endtask

  task automatic directed(input logic [15:0] al, input logic [15:0] bl, input logic [15:0] ar,
                          input logic [15:0] br, input logic m, input logic [15:0] el,
                          input logic [15:0] er, input string name);
    psg_l = al; pcm_l = bl; psg_r = ar; pcm_r = br; mute = m;
    step(1100);
    for (int k = 0; k < 2; k++) begin
      chk({name, "_left"}, k, int'(cap_l[k]), int'(el));
      chk({name, "_right"}, k, int'(cap_r[k]), int'(er));
    end
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; mute = 1'b0;
    psg_l = 16'h1111; psg_r = 16'h2222; pcm_l = 16'h3333; pcm_r = 16'h4444;
    step(5);
    chk("reset_outputs", 0, int'({ns[0], bck[0], lr[0], dat[0]}), 0);
    chk("reset_outputs", 1, int'({ns[1], bck[1], lr[1], dat[1]}), 0);
    rst_n = 1'b1;
    random_run(3000, 1'b0);
    directed(16'h8001, 16'h0000, 16'h00FF, 16'h0000, 1'b0, 16'h8001, 16'h00FF, "serial");
    directed(16'h7000, 16'h7000, 16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 16'h8000, "sat");
    directed(16'h1234, 16'hFFFF, 16'h0001, 16'h0002, 1'b0, 16'h1233, 16'h0003, "sat2");
    directed(16'h5A5A, 16'h0101, 16'hA5A5, 16'h0202, 1'b1, 16'h0000, 16'h0000, "mute");
    random_run(2500, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      step(1);
      if (((cyc[0] % 512) / 8) == 20) found = 1'b1;
    end
    chk("reach_bit20", 0, int'(found), 1);
    rst_n = 1'b0;
    step(1);
    chk("midreset_outputs", 0, int'({ns[0], bck[0], lr[0], dat[0]}), 0);
    rst_n = 1'b1;
    random_run(1200, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
